// File: rtl/admode2_ldst_unit.sv
// Single-data-transfer unit for LDR/STR/LDRB/STRB with an addressing-mode-2 offset.
// Drives a req/ack data-memory port and produces Rd/Rn register-file writebacks.
module admode2_ldst_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] instr,
   input  logic [31:0] rn,
   input  logic [31:0] rd_val,
   input  logic [31:0] offset,
   output logic        busy,
   output logic        done,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        rd_we,
   output logic [3:0]  rd_idx,
   output logic [31:0] rd_data,
   output logic        rn_we,
   output logic [3:0]  rn_idx,
   output logic [31:0] rn_data
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_r;
   state_t      state_nxt_s;

   logic        p_r;
   logic        b_r;
   logic        w_r;
   logic        l_r;
   logic [3:0]  rn_idx_q_r;
   logic [3:0]  rd_idx_q_r;
   logic [1:0]  lane_r;
   logic [31:0] calc_r;

   logic [31:0] calc_s;
   logic [31:0] ea_s;
   logic        unused_instr_s;

   // Rotate the read word so the addressed byte lands in bits [7:0]; byte loads keep only that lane.
   function automatic logic [31:0] align_load(input logic [31:0] data,
                                              input logic [1:0]  lane,
                                              input logic        byte_mode);
      logic [63:0] dbl;
      logic [31:0] rot;
      dbl = {data, data} >> {lane, 3'b000};
      rot = dbl[31:0];
      if (byte_mode) begin
         return {24'h00_0000, rot[7:0]};
      end else begin
         return rot;
      end
   endfunction

   assign calc_s = instr[23] ? (rn + offset) : (rn - offset);
   assign ea_s   = instr[24] ? calc_s : rn;

   assign unused_instr_s = ^{instr[31:25], instr[11:0]};

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; start is only honoured in IDLE and ack only in REQ.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nxt_s = REQ;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         REQ: begin
            if (mem_ack) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = REQ;
            end
         end
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Registered bus and writeback outputs plus the operands latched at start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy       <= 1'b0;
         done       <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= 32'h0000_0000;
         mem_wdata  <= 32'h0000_0000;
         mem_be     <= 4'h0;
         rd_we      <= 1'b0;
         rd_idx     <= 4'h0;
         rd_data    <= 32'h0000_0000;
         rn_we      <= 1'b0;
         rn_idx     <= 4'h0;
         rn_data    <= 32'h0000_0000;
         p_r        <= 1'b0;
         b_r        <= 1'b0;
         w_r        <= 1'b0;
         l_r        <= 1'b0;
         rn_idx_q_r <= 4'h0;
         rd_idx_q_r <= 4'h0;
         lane_r     <= 2'b00;
         calc_r     <= 32'h0000_0000;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  p_r        <= instr[24];
                  b_r        <= instr[22];
                  w_r        <= instr[21];
                  l_r        <= instr[20];
                  rn_idx_q_r <= instr[19:16];
                  rd_idx_q_r <= instr[15:12];
                  lane_r     <= ea_s[1:0];
                  calc_r     <= calc_s;
                  busy       <= 1'b1;
                  mem_req    <= 1'b1;
                  mem_we     <= ~instr[20];
                  mem_addr   <= {ea_s[31:2], 2'b00};
                  if (instr[20]) begin
                     mem_be    <= 4'hF;
                     mem_wdata <= 32'h0000_0000;
                  end else if (instr[22]) begin
                     mem_be    <= 4'b0001 << ea_s[1:0];
                     mem_wdata <= {4{rd_val[7:0]}};
                  end else begin
                     mem_be    <= 4'hF;
                     mem_wdata <= rd_val;
                  end
               end
            end
            REQ: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  done    <= 1'b1;
                  rd_we   <= l_r;
                  // A load into the base register takes priority over writeback.
                  rn_we   <= (~p_r | w_r) & ~(l_r & (rn_idx_q_r == rd_idx_q_r));
                  rn_data <= calc_r;
                  rd_idx  <= rd_idx_q_r;
                  rn_idx  <= rn_idx_q_r;
                  if (l_r) begin
                     rd_data <= align_load(mem_rdata, lane_r, b_r);
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               rd_we <= 1'b0;
               rn_we <= 1'b0;
            end
            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               mem_req <= 1'b0;
               rd_we   <= 1'b0;
               rn_we   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_admode2_ldst_unit.sv
// Directed-vector bench for admode2_ldst_unit with hand-computed expectations.
module tb_admode2_ldst_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] instr;
   logic [31:0] rn;
   logic [31:0] rd_val;
   logic [31:0] offset;
   logic        busy;
   logic        done;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        rd_we;
   logic [3:0]  rd_idx;
   logic [31:0] rd_data;
   logic        rn_we;
   logic [3:0]  rn_idx;
   logic [31:0] rn_data;

   int n_vec  = 0;
   int n_fail = 0;

   admode2_ldst_unit dut (
      .clk(clk), .rst(rst), .start(start), .instr(instr), .rn(rn),
      .rd_val(rd_val), .offset(offset), .busy(busy), .done(done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .rd_we(rd_we), .rd_idx(rd_idx),
      .rd_data(rd_data), .rn_we(rn_we), .rn_idx(rn_idx), .rn_data(rn_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mk(input logic p, input logic u, input logic b,
                                      input logic w, input logic l,
                                      input logic [3:0] rn_i, input logic [3:0] rd_i);
      return 32'hE400_0000 | {7'd0, p, u, b, w, l, rn_i, rd_i, 12'd0};
   endfunction

   task automatic chk_all_zero(input string nm);
      chk({nm, ":busy"},      {31'd0, busy},    32'd0);
      chk({nm, ":done"},      {31'd0, done},    32'd0);
      chk({nm, ":mem_req"},   {31'd0, mem_req}, 32'd0);
      chk({nm, ":mem_we"},    {31'd0, mem_we},  32'd0);
      chk({nm, ":mem_addr"},  mem_addr,         32'd0);
      chk({nm, ":mem_wdata"}, mem_wdata,        32'd0);
      chk({nm, ":mem_be"},    {28'd0, mem_be},  32'd0);
      chk({nm, ":rd_we"},     {31'd0, rd_we},   32'd0);
      chk({nm, ":rd_idx"},    {28'd0, rd_idx},  32'd0);
      chk({nm, ":rd_data"},   rd_data,          32'd0);
      chk({nm, ":rn_we"},     {31'd0, rn_we},   32'd0);
      chk({nm, ":rn_idx"},    {28'd0, rn_idx},  32'd0);
      chk({nm, ":rn_data"},   rn_data,          32'd0);
   endtask

   // One transfer: start held through the whole transfer with inputs scrambled after the first edge.
   task automatic xfer(input string nm, input logic [31:0] ins, input logic [31:0] rnv,
                       input logic [31:0] rdv, input logic [31:0] off, input logic [31:0] rdata,
                       input int dly, input logic [31:0] e_addr, input logic [3:0] e_be,
                       input logic [31:0] e_wdata, input logic e_we, input logic e_rd_we,
                       input logic [31:0] e_rd_data, input logic e_rn_we,
                       input logic [31:0] e_rn_data);
      instr  = ins;
      rn     = rnv;
      rd_val = rdv;
      offset = off;
      start  = 1'b1;
      tick();
      instr  = ins ^ 32'h01B0_0000;
      rn     = 32'hA5A5_0F0F;
      rd_val = ~rdv;
      offset = 32'h0000_0100;
      for (int i = 0; i <= dly; i++) begin
         chk({nm, ":req"},   {31'd0, mem_req}, 32'd1);
         chk({nm, ":busy"},  {31'd0, busy},    32'd1);
         chk({nm, ":done0"}, {31'd0, done},    32'd0);
         chk({nm, ":addr"},  mem_addr,         e_addr);
         chk({nm, ":we"},    {31'd0, mem_we},  {31'd0, e_we});
         chk({nm, ":be"},    {28'd0, mem_be},  {28'd0, e_be});
         chk({nm, ":wdata"}, mem_wdata,        e_wdata);
         mem_ack   = (i == dly);
         mem_rdata = (i == dly) ? rdata : 32'hBAD0_BAD0;
         tick();
      end
      mem_ack   = 1'b0;
      mem_rdata = 32'h0000_0000;
      chk({nm, ":done"},    {31'd0, done},    32'd1);
      chk({nm, ":req_off"}, {31'd0, mem_req}, 32'd0);
      chk({nm, ":rd_we"},   {31'd0, rd_we},   {31'd0, e_rd_we});
      chk({nm, ":rn_we"},   {31'd0, rn_we},   {31'd0, e_rn_we});
      chk({nm, ":rn_data"}, rn_data,          e_rn_data);
      chk({nm, ":rd_idx"},  {28'd0, rd_idx},  {28'd0, ins[15:12]});
      chk({nm, ":rn_idx"},  {28'd0, rn_idx},  {28'd0, ins[19:16]});
      if (e_rd_we) begin
         chk({nm, ":rd_data"}, rd_data, e_rd_data);
      end
      tick();
      start = 1'b0;
      chk({nm, ":idle_busy"}, {31'd0, busy},    32'd0);
      chk({nm, ":idle_done"}, {31'd0, done},    32'd0);
      chk({nm, ":idle_rdwe"}, {31'd0, rd_we},   32'd0);
      chk({nm, ":idle_rnwe"}, {31'd0, rn_we},   32'd0);
      chk({nm, ":idle_req"},  {31'd0, mem_req}, 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      instr     = 32'h0000_0000;
      rn        = 32'h0000_0000;
      rd_val    = 32'h0000_0000;
      offset    = 32'h0000_0000;
      mem_ack   = 1'b0;
      mem_rdata = 32'h0000_0000;
      repeat (2) tick();
      chk_all_zero("reset");
      rst = 1'b0;
      tick();

      xfer("str_word", mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2), 32'h0000_1000,
           32'hDEAD_BEEF, 32'h0000_0008, 32'h0, 0, 32'h0000_1008, 4'hF, 32'hDEAD_BEEF,
           1'b1, 1'b0, 32'h0, 1'b0, 32'h0000_1008);
      xfer("ldr_unal", mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 4'd5), 32'h0000_2005,
           32'h0, 32'h0000_0004, 32'h1122_3344, 0, 32'h0000_2000, 4'hF, 32'h0,
           1'b0, 1'b1, 32'h4411_2233, 1'b0, 32'h0000_2001);
      xfer("ldrb_post", mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd6, 4'd7), 32'h0000_3003,
           32'h0, 32'h0000_0010, 32'hAABB_CCDD, 1, 32'h0000_3000, 4'hF, 32'h0,
           1'b0, 1'b1, 32'h0000_00AA, 1'b1, 32'h0000_3013);
      xfer("strb_wb", mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd8, 4'd9), 32'h0000_4002,
           32'h0000_005A, 32'h0, 32'h0, 3, 32'h0000_4000, 4'b0100, 32'h5A5A_5A5A,
           1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_4002);
      xfer("ldr_rn_eq_rd", mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd4, 4'd4), 32'h0000_0100,
           32'h0, 32'h0000_0004, 32'hCAFE_F00D, 1, 32'h0000_0104, 4'hF, 32'h0,
           1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 32'h0000_0104);
      xfer("ldrb_lane1", mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd12, 4'd13), 32'h0000_5000,
           32'h0, 32'h0000_0001, 32'h1122_3344, 0, 32'h0000_5000, 4'hF, 32'h0,
           1'b0, 1'b1, 32'h0000_0033, 1'b0, 32'h0000_5001);

      // Reset while a request is outstanding, then a late ack that must be ignored.
      instr  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2);
      rn     = 32'h0000_6000;
      rd_val = 32'h0BAD_F00D;
      offset = 32'h0000_0004;
      start  = 1'b1;
      tick();
      start = 1'b0;
      chk("rst_mid:req", {31'd0, mem_req}, 32'd1);
      rst = 1'b1;
      #1;
      chk_all_zero("rst_mid");
      tick();
      rst     = 1'b0;
      mem_ack = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("late_ack:done", {31'd0, done},    32'd0);
         chk("late_ack:req",  {31'd0, mem_req}, 32'd0);
         chk("late_ack:busy", {31'd0, busy},    32'd0);
      end
      mem_ack = 1'b0;
      tick();

      xfer("str_wrap", mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd10, 4'd11), 32'h0000_0000,
           32'h1234_5678, 32'h0000_0004, 32'h0, 0, 32'hFFFF_FFFC, 4'hF, 32'h1234_5678,
           1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/admode2_ldst_unit.md
Name: admode2_ldst_unit

Overview:
- Executes a single-data-transfer instruction (LDR/STR/LDRB/STRB) using a precomputed addressing-mode-2 offset.
- Computes the effective and writeback addresses and runs a req/ack handshake with the data-memory port.
- Aligns load data and produces register-file write strobes for Rd and the base register Rn.
- Sits between the execute stage (which supplies rn, rd_val and offset) and the memory bus.

Parameters:
- none. Widths are fixed at 32-bit data and address, 4-bit byte enables and 4-bit register index.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  launch a transfer; sampled only in IDLE
- instr  in  32  instruction word; uses P=[24], U=[23], B=[22], W=[21], L=[20], Rn=[19:16], Rd=[15:12]
- rn  in  32  base register value
- rd_val  in  32  store source value (Rd)
- offset  in  32  addressing-mode-2 offset, already shifted
- busy  out  1  high in REQ and DONE
- done  out  1  one-cycle completion pulse
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  32  word-aligned address
- mem_wdata  out  32  store data
- mem_be  out  4  byte enables
- mem_ack  in  1  memory accepted / read data valid
- mem_rdata  in  32  read data, valid with mem_ack
- rd_we  out  1  write Rd (loads only)
- rd_idx  out  4  Rd index
- rd_data  out  32  aligned load result
- rn_we  out  1  write back base register
- rn_idx  out  4  Rn index
- rn_data  out  32  updated base value

Behaviour:
- Reset (async, active-high): state forced to IDLE. All outputs are 0: busy, done, mem_req, mem_we, mem_addr, mem_wdata, mem_be, rd_we, rd_idx, rd_data, rn_we, rn_idx, rn_data.
- Start capture: on start in IDLE, latch instr fields, rd_val, and the two addresses below.
  - calc = U ? rn+offset : rn-offset, modulo 2^32, wrap-around silently.
  - ea = P ? calc : rn.
- States: IDLE -> REQ (cycle after start) -> DONE (cycle after mem_ack sampled high in REQ) -> IDLE (next cycle).
- REQ state:
  - mem_req=1.
  - mem_addr={ea[31:2],2'b00}; mem_we=~L.
  - Store word: mem_wdata=rd_val, mem_be=4'hF.
  - Store byte: mem_wdata={4{rd_val[7:0]}}, mem_be=4'b0001<<ea[1:0].
  - Load: mem_be=4'hF, mem_wdata=0.
  - All of these stay stable until mem_ack. mem_req never deasserts without an ack, except on reset.
- Load data capture, on the ack edge:
  - word: rd_data = mem_rdata rotated right by 8*ea[1:0].
  - byte: rd_data = zero-extended byte lane ea[1:0].
- DONE state (exactly 1 cycle):
  - done=1; mem_req=0.
  - rd_we=L.
  - rn_we=(~P | W), except forced to 0 when L=1 and Rn==Rd, so the load wins.
  - rn_data=calc.
  - rd_idx and rn_idx hold the latched indices.
- Strobes: done, rd_we and rn_we are 0 in all other states. rd_data, rn_data, rd_idx and rn_idx hold their last values.
- Minimum latency: start edge to done = 2 cycles with ack in the first REQ cycle. Ack delayed by k cycles adds k.
- Ignored inputs:
  - start while busy; inputs are not resampled.
  - mem_ack outside REQ.
- Back-to-back: start may be asserted in the DONE cycle but is only sampled in IDLE, so the issue rate is 1 transfer per 3 cycles minimum.
- Reset mid-transfer: immediate return to IDLE, mem_req drops, no writeback strobes.

Test Plan:
- STR word, P=1 U=1 W=0, rn=0x1000, offset=0x8, rd_val=0xDEADBEEF, ack immediate -> mem_addr=0x1008, mem_we=1, be=F, wdata=0xDEADBEEF; done 2 cycles after start; rn_we=0, rd_we=0.
- LDR word unaligned, P=1 U=0, rn=0x2005, offset=0x4, mem_rdata=0x11223344 -> mem_addr=0x2000, ea[1:0]=1; rd_data=0x44112233, rd_we=1.
- LDRB post-index (P=0), rn=0x3003, offset=0x10, U=1, mem_rdata=0xAABBCCDD -> mem_addr=0x3000, rd_data=0x000000AA, rn_we=1, rn_data=0x3013.
- STRB pre-index with writeback (W=1), rn=0x4002, offset=0, rd_val=0x5A -> be=4'b0100, wdata=0x5A5A5A5A, rn_data=0x4002; ack delayed 3 cycles -> mem_req and mem_addr stable for 4 cycles, done 5 cycles after start.
- Edge cases:
  - LDR with W=1 and Rn==Rd=4 -> rd_we=1, rn_we=0.
  - U=0, rn=0, offset=4 -> calc=0xFFFFFFFC (wrap).
- Assert rst in REQ before ack -> all outputs 0 the same cycle. A later ack is ignored, no done. A new start afterwards runs normally.
